trie_lookup_engine: RTL and testbench
=====================================

# trie_lookup_engine

Parametrised multibit-trie IP lookup engine: walks a level-ordered bitmap trie stored in SRAM, one stride of the lookup address per level, and returns the DRAM leaf address of the longest match. It generalises the fixed 32-bit/4-bit-stride datapath into a self-sequencing block with its own FSM, a start/done handshake and a configurable SRAM read latency. It sits between the packet front end (lookup requests) and the next-hop DRAM reader.

## Interface
- ADDR_W, 32, lookup address width; must be a multiple of STRIDE.
- STRIDE, 4, address bits consumed per level; bitmap has B = 2**STRIDE bits.
- CNT_W, 8, width of each prefix-count field in an SRAM row.
- RAM_AW, 10, SRAM row address width.
- DRAM_AW, 10, DRAM address width.
- RD_LAT, 1, SRAM read latency in cycles (>=1).
- Derived: L = ADDR_W/STRIDE levels; ROW_W = 2*CNT_W + B; DEP_W = clog2(L)+1.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request pulse; accepted only in IDLE.
- address  in  ADDR_W  lookup key, captured on accepted start.
- busy  out  1  high in every state except IDLE.
- sram_rd  out  1  one-cycle SRAM read strobe.
- next_sram_row  out  RAM_AW  SRAM row address, valid with sram_rd.
- sram_row_data  in  ROW_W  row read data, valid RD_LAT cycles after sram_rd.
- dram_address  out  DRAM_AW  result, valid with done, held until next done.
- done  out  1  one-cycle completion pulse.
- err  out  1  malformed-trie flag, valid with done, held.
- depth  out  DEP_W  levels visited (1..L), valid with done, held.

## Operation
- Row format: {child_prefix[CNT_W], leaf_prefix[CNT_W], bitmap[B]}. child_prefix = count of 1 bits in all earlier rows of the table; leaf_prefix = count of 0 bits in all earlier rows. Root is row 0; rows stored level by level.
- Level k uses index idx = address chunk k, MSB-first (k=0 → address[ADDR_W-1 -: STRIDE]). Selected bit = bitmap[B-1-idx].
- ones_before / zeros_before = popcount of 1s / 0s in bitmap[B-1 : B-idx] (positions before idx); zero when idx=0.
- Bit=1 and k<L-1: next row = child_prefix + ones_before + 1, computed at RAM_AW+1 bits; if result >= 2**RAM_AW, finish with err=1. Otherwise k increments and the next level is read.
- Bit=1 and k=L-1: finish with err=1, dram_address=0.
- Bit=0: finish with dram_address = (leaf_prefix + zeros_before) truncated to DRAM_AW, err=0.
- depth = k+1 at finish.
- FSM: IDLE → ISSUE on start. ISSUE (sram_rd=1, one cycle) → WAIT (RD_LAT-1 cycles, skipped when RD_LAT=1) → EVAL (data cycle) → ISSUE or DONE. DONE (done=1, one cycle) → IDLE.
- start while not IDLE is ignored, including in the DONE cycle. Start in the IDLE cycle after DONE is accepted.
- Reset values: busy=0, sram_rd=0, next_sram_row=0, dram_address=0, done=0, err=0, depth=0, FSM=IDLE.
- Reset mid-lookup aborts immediately: no done pulse, all outputs at reset values.

## Timing
- Start sampled at cycle 0 edge; first ISSUE in cycle 1.
- Per level: RD_LAT+1 cycles (ISSUE + RD_LAT); EVAL coincides with the last wait cycle.
- done asserted in cycle 1 + d*(RD_LAT+1) for d levels visited.
- Example: RD_LAT=1, d=1 → done in cycle 3.
- sram_rd, next_sram_row, done, dram_address, err and depth are all registered outputs.
- Maximum throughput: one lookup per 2 + L*(RD_LAT+1) cycles.

## Configuration
- TRIE_ROW_REG_EN defined: sram_row_data is registered before EVAL. Each level takes RD_LAT+2 cycles; done arrives in cycle 1 + d*(RD_LAT+2).
- TRIE_ROW_REG_EN undefined: EVAL is combinational on sram_row_data, with timing as above.
- Results are identical in both builds.

## Test plan
- Default parameters, RD_LAT=1. Row0 = {0, 5, 0x0000}, address 0x3000_0000 → dram_address=8, err=0, depth=1, done in cycle 3.
- Row0 = {0, 0, 0x9000}, row2 = {2, 14, 0x0000}, address 0x3500_0000. Expected: idx3 set with ones_before=1 → read row 2; idx5 clear → dram_address=19, depth=2, done in cycle 5, second next_sram_row=2.
- Every row bitmap 0xFFFF with small prefixes → err=1, dram_address=0, depth=8, done in cycle 17.
- RD_LAT=3: assert reset during WAIT of level 1 → all outputs 0 next cycle, no done; a fresh start then completes normally.
- Hold start high for 20 cycles across one lookup → exactly one done; the next lookup starts only in the IDLE cycle after DONE, and busy is low for exactly that one cycle.
- Build with TRIE_ROW_REG_EN: repeat the two-level case → same results, done in cycle 7.

Source files
------------

// File: rtl/trie_lookup_engine.sv
// Multibit-trie longest-prefix lookup engine: walks a level-ordered bitmap trie in SRAM.
// Define TRIE_ROW_REG_EN to register the SRAM row before evaluation (one extra cycle per level).
module trie_lookup_engine #(
    parameter int ADDR_W  = 32,
    parameter int STRIDE  = 4,
    parameter int CNT_W   = 8,
    parameter int RAM_AW  = 10,
    parameter int DRAM_AW = 10,
    parameter int RD_LAT  = 1,
    localparam int B      = 2**STRIDE,
    localparam int L      = ADDR_W / STRIDE,
    localparam int ROW_W  = 2*CNT_W + B,
    localparam int DEP_W  = $clog2(L) + 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [ADDR_W-1:0]  i_address,
    output logic               o_busy,
    output logic               o_sram_rd,
    output logic [RAM_AW-1:0]  o_next_sram_row,
    input  logic [ROW_W-1:0]   i_sram_row_data,
    output logic [DRAM_AW-1:0] o_dram_address,
    output logic               o_done,
    output logic               o_err,
    output logic [DEP_W-1:0]   o_depth
);
`ifdef TRIE_ROW_REG_EN
    localparam int WAIT_CYC = RD_LAT;
`else
    localparam int WAIT_CYC = RD_LAT - 1;
`endif
    localparam int WCNT_W = $clog2(WAIT_CYC + 1) + 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EVAL, S_DONE} state_t;

    state_t               r_state, w_next_state;
    logic [ADDR_W-1:0]    r_key;
    logic [DEP_W-1:0]     r_level;
    logic [WCNT_W-1:0]    r_wait;
    logic                 r_busy, r_sram_rd, r_done, r_err;
    logic [RAM_AW-1:0]    r_next_row;
    logic [DRAM_AW-1:0]   r_dram;
    logic [DEP_W-1:0]     r_depth;
    logic [ROW_W-1:0]     w_row;
    logic [STRIDE-1:0]    w_idx;
    logic [B-1:0]         w_bitmap;
    logic [CNT_W-1:0]     w_leaf_prefix, w_child_prefix;
    logic [STRIDE:0]      w_ones, w_zeros;
    logic                 w_bit, w_last, w_overflow;
    logic [RAM_AW:0]      w_child_row;
    logic [CNT_W:0]       w_leaf_sum;

`ifdef TRIE_ROW_REG_EN
    logic [ROW_W-1:0]     r_row;

    // Row capture register; EVAL reads the row one cycle after it arrives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row <= '0;
        end else begin
            r_row <= i_sram_row_data;
        end
    end
    assign w_row = r_row;
`else
    assign w_row = i_sram_row_data;
`endif

    // Level evaluation: field split, selected bit, prefix counts before idx, child/leaf sums.
    always_comb begin
        w_idx          = r_key[ADDR_W-1 -: STRIDE];
        w_bitmap       = w_row[B-1:0];
        w_leaf_prefix  = w_row[B +: CNT_W];
        w_child_prefix = w_row[B+CNT_W +: CNT_W];
        w_bit          = w_bitmap[STRIDE'(B-1) - w_idx];
        w_ones         = '0;
        for (int j = 0; j < B; j++) begin
            if (j < int'(w_idx)) begin
                w_ones = w_ones + (STRIDE+1)'(w_bitmap[B-1-j]);
            end else begin
                w_ones = w_ones;
            end
        end
        w_zeros     = {1'b0, w_idx} - w_ones;
        w_child_row = (RAM_AW+1)'(w_child_prefix) + (RAM_AW+1)'(w_ones) + (RAM_AW+1)'(1'b1);
        w_leaf_sum  = (CNT_W+1)'(w_leaf_prefix) + (CNT_W+1)'(w_zeros);
        w_last      = (r_level == DEP_W'(L-1));
        w_overflow  = w_child_row[RAM_AW];
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next_state = S_ISSUE;
                else         w_next_state = S_IDLE;
            end
            S_ISSUE: begin
                if (WAIT_CYC == 0) w_next_state = S_EVAL;
                else               w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait == WCNT_W'(WAIT_CYC - 1)) w_next_state = S_EVAL;
                else                                 w_next_state = S_WAIT;
            end
            S_EVAL: begin
                if (w_bit && !w_last && !w_overflow) w_next_state = S_ISSUE;
                else                                 w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, walk context and registered outputs (outputs follow the state being entered).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_key      <= '0;
            r_level    <= '0;
            r_wait     <= '0;
            r_busy     <= 1'b0;
            r_sram_rd  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_next_row <= '0;
            r_dram     <= '0;
            r_depth    <= '0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= (w_next_state != S_IDLE);
            r_sram_rd <= (w_next_state == S_ISSUE);
            r_done    <= (w_next_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_key      <= i_address;
                        r_level    <= '0;
                        r_next_row <= '0;
                    end
                end
                S_ISSUE: r_wait <= '0;
                S_WAIT:  r_wait <= r_wait + WCNT_W'(1);
                S_EVAL: begin
                    if (w_next_state == S_ISSUE) begin
                        r_key      <= r_key << STRIDE;
                        r_level    <= r_level + DEP_W'(1);
                        r_next_row <= w_child_row[RAM_AW-1:0];
                    end else begin
                        // Finishing on a set bit means last level or row overflow: malformed trie.
                        r_depth <= r_level + DEP_W'(1);
                        r_err   <= w_bit;
                        r_dram  <= w_bit ? DRAM_AW'(0) : DRAM_AW'(w_leaf_sum);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_sram_rd       = r_sram_rd;
    assign o_next_sram_row = r_next_row;
    assign o_dram_address  = r_dram;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_depth         = r_depth;
endmodule

// File: tb/tb_trie_lookup_engine.sv
// Self-checking bench for trie_lookup_engine: two instances (RD_LAT=1 and RD_LAT=3), shared SRAM image.
module tb_trie_lookup_engine;
    localparam int ADDR_W = 32, STRIDE = 4, CNT_W = 8, RAM_AW = 10, DRAM_AW = 10;
    localparam int B = 16, L = 8, ROW_W = 32, DEP_W = 4;
    localparam int RD_A = 1, RD_B = 3;
`ifdef TRIE_ROW_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int PER_A = RD_A + 1 + EXTRA;
    localparam int PER_B = RD_B + 1 + EXTRA;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               a_start, b_start;
    logic [ADDR_W-1:0]  a_addr, b_addr;
    logic               a_busy, b_busy, a_sram_rd, b_sram_rd;
    logic [RAM_AW-1:0]  a_row, b_row;
    logic [ROW_W-1:0]   a_data, b_data;
    logic [DRAM_AW-1:0] a_dram, b_dram;
    logic               a_done, b_done, a_err, b_err;
    logic [DEP_W-1:0]   a_depth, b_depth;

    trie_lookup_engine #(.RD_LAT(RD_A)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_address(a_addr),
        .o_busy(a_busy), .o_sram_rd(a_sram_rd), .o_next_sram_row(a_row),
        .i_sram_row_data(a_data), .o_dram_address(a_dram), .o_done(a_done),
        .o_err(a_err), .o_depth(a_depth));

    trie_lookup_engine #(.RD_LAT(RD_B)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_address(b_addr),
        .o_busy(b_busy), .o_sram_rd(b_sram_rd), .o_next_sram_row(b_row),
        .i_sram_row_data(b_data), .o_dram_address(b_dram), .o_done(b_done),
        .o_err(b_err), .o_depth(b_depth));

    // SRAM image plus per-instance read pipelines; data is inverted garbage outside the valid cycle.
    logic [ROW_W-1:0] mem [1024];
    logic [RAM_AW:0]  a_pipe [RD_A];
    logic [RAM_AW:0]  b_pipe [RD_B];

    always @(posedge clk) begin
        a_pipe[0] <= {a_sram_rd, a_row};
        for (int i = 1; i < RD_A; i++) a_pipe[i] <= a_pipe[i-1];
        b_pipe[0] <= {b_sram_rd, b_row};
        for (int i = 1; i < RD_B; i++) b_pipe[i] <= b_pipe[i-1];
    end

    always_comb begin
        a_data = a_pipe[RD_A-1][RAM_AW] ? mem[a_pipe[RD_A-1][RAM_AW-1:0]] : ~mem[a_pipe[RD_A-1][RAM_AW-1:0]];
        b_data = b_pipe[RD_B-1][RAM_AW] ? mem[b_pipe[RD_B-1][RAM_AW-1:0]] : ~mem[b_pipe[RD_B-1][RAM_AW-1:0]];
    end

    int qa[$];
    int qb[$];
    always @(negedge clk) begin
        if (a_sram_rd) qa.push_back(int'(a_row));
        if (b_sram_rd) qb.push_back(int'(b_row));
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: walks the trie from the rules with integer arithmetic.
    int                 m_rows[$];
    logic [DRAM_AW-1:0] m_dram;
    logic               m_err;
    int                 m_depth;

    function automatic void model(input logic [ADDR_W-1:0] addr);
        int row, idx, bm, ones, child, leaf;
        logic [ROW_W-1:0] r;
        m_rows.delete();
        m_err   = 1'b0;
        m_dram  = '0;
        m_depth = 0;
        row     = 0;
        for (int k = 0; k < L; k++) begin
            r = mem[row];
            m_rows.push_back(row);
            m_depth = k + 1;
            idx   = int'(addr >> (ADDR_W - STRIDE*(k+1))) & (B - 1);
            bm    = int'(r[B-1:0]);
            leaf  = int'(r[B+CNT_W-1:B]);
            child = int'(r[ROW_W-1:B+CNT_W]);
            ones  = (idx == 0) ? 0 : $countones(bm >> (B - idx));
            if (((bm >> (B - 1 - idx)) & 1) == 0) begin
                m_dram = DRAM_AW'(leaf + idx - ones);
                return;
            end
            if (k == L - 1) begin
                m_err = 1'b1;
                return;
            end
            row = child + ones + 1;
            if (row >= (1 << RAM_AW)) begin
                m_err = 1'b1;
                return;
            end
        end
    endfunction

    task automatic lookup(input bit sel, input logic [ADDR_W-1:0] addr, input string tag, output int cyc);
        int per;
        model(addr);
        per = sel ? PER_B : PER_A;
        @(negedge clk);
        if (sel) begin qb.delete(); b_addr = addr; b_start = 1'b1; end
        else     begin qa.delete(); a_addr = addr; a_start = 1'b1; end
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        check({tag, ".busy"}, sel ? b_busy : a_busy, 32'd1);
        cyc = 1;
        while (!(sel ? b_done : a_done) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".cycle"}, cyc, 32'(1 + m_depth*per));
        check({tag, ".dram"},  sel ? b_dram : a_dram,   32'(m_dram));
        check({tag, ".err"},   sel ? b_err : a_err,     32'(m_err));
        check({tag, ".depth"}, sel ? b_depth : a_depth, 32'(m_depth));
        check({tag, ".nrows"}, sel ? qb.size() : qa.size(), 32'(m_rows.size()));
        for (int i = 0; i < m_rows.size(); i++) begin
            if (i < (sel ? qb.size() : qa.size())) begin
                check({tag, ".row"}, sel ? qb[i] : qa[i], 32'(m_rows[i]));
            end
        end
    endtask

    initial begin
        int cyc, n_done, n_idle, first, exp_done, exp_idle, exp_first;
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; a_addr = '0; b_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        check("rst.busy",  a_busy,    32'd0);
        check("rst.rd",    a_sram_rd, 32'd0);
        check("rst.row",   a_row,     32'd0);
        check("rst.dram",  a_dram,    32'd0);
        check("rst.done",  a_done,    32'd0);
        check("rst.err",   a_err,     32'd0);
        check("rst.depth", a_depth,   32'd0);
        rst = 1'b0;

        // Single-level leaf.
        mem[0] = {8'd0, 8'd5, 16'h0000};
        lookup(1'b0, 32'h3000_0000, "t1", cyc);
        check("t1.dram_c",  a_dram,  32'd8);
        check("t1.depth_c", a_depth, 32'd1);
        check("t1.cyc_c",   cyc,     32'(1 + PER_A));

        // Two-level walk: root idx3 set, row 2 idx5 clear.
        mem[0] = {8'd0, 8'd0, 16'h9000};
        mem[2] = {8'd2, 8'd14, 16'h0000};
        lookup(1'b0, 32'h3500_0000, "t2", cyc);
        check("t2.dram_c", a_dram, 32'd19);
        check("t2.cyc_c",  cyc,    32'(1 + 2*PER_A));
        check("t2.row1_c", (qa.size() > 1) ? qa[1] : -1, 32'd2);

        // Every bit set: runs off the last level.
        for (int i = 0; i < 1024; i++) mem[i] = {8'd0, 8'd3, 16'hFFFF};
        lookup(1'b0, 32'h1234_5678, "t3", cyc);
        check("t3.err_c",   a_err,   32'd1);
        check("t3.dram_c",  a_dram,  32'd0);
        check("t3.depth_c", a_depth, 32'd8);
        check("t3.cyc_c",   cyc,     32'(1 + 8*PER_A));

        // Start held high: one lookup at a time, restart only from the single IDLE cycle.
        mem[0] = {8'd0, 8'd5, 16'h0000};
        @(negedge clk);
        a_start = 1'b1; a_addr = 32'h3000_0000;
        n_done = 0; n_idle = 0; first = 0;
        exp_done = 0; exp_idle = 0; exp_first = 1 + PER_A;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (a_done) begin
                n_done++;
                if (first == 0) first = c;
            end
            if (!a_busy) n_idle++;
            if (c >= 1 + PER_A && (c - 1 - PER_A) % (2 + PER_A) == 0) exp_done++;
            if (c >= 2 + PER_A && (c - 2 - PER_A) % (2 + PER_A) == 0) exp_idle++;
        end
        a_start = 1'b0;
        check("hold.ndone", n_done, 32'(exp_done));
        check("hold.nidle", n_idle, 32'(exp_idle));
        check("hold.first", first,  32'(exp_first));
        repeat (2 + 2*PER_A) @(negedge clk);

        // Random tries against the model.
        for (int i = 0; i < 1024; i++) begin
            mem[i] = {8'($urandom_range(0, 200)), 8'($urandom),
                      (i % 2 == 1) ? 16'($urandom & $urandom) : 16'($urandom | $urandom)};
        end
        for (int t = 0; t < 30; t++) lookup(1'b0, 32'($urandom), "rnd", cyc);
        for (int t = 0; t < 6; t++)  lookup(1'b1, 32'($urandom), "rndb", cyc);

        // RD_LAT=3: complete a deep lookup, then reset during level-1 WAIT of the next one.
        for (int i = 0; i < 1024; i++) mem[i] = {8'd0, 8'd3, 16'hFFFF};
        lookup(1'b1, 32'hFEDC_BA98, "b3", cyc);
        @(negedge clk);
        b_start = 1'b1; b_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        b_start = 1'b0;
        repeat (1 + PER_B) @(negedge clk);
        check("babort.busy_pre", b_busy, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("babort.busy",  b_busy,    32'd0);
        check("babort.rd",    b_sram_rd, 32'd0);
        check("babort.row",   b_row,     32'd0);
        check("babort.dram",  b_dram,    32'd0);
        check("babort.done",  b_done,    32'd0);
        check("babort.err",   b_err,     32'd0);
        check("babort.depth", b_depth,   32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b_done) n_done++;
        end
        check("babort.nodone", n_done, 32'd0);
        mem[0] = {8'd0, 8'd0, 16'h9000};
        mem[2] = {8'd2, 8'd14, 16'h0000};
        lookup(1'b1, 32'h3500_0000, "bfresh", cyc);
        check("bfresh.dram_c", b_dram, 32'd19);
        check("bfresh.cyc_c",  cyc,    32'(1 + 2*PER_B));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
